// File: rtl/gates_sweep.sv
// gates_sweep: sweeps every N-bit input vector through a selectable logic
// gate, reporting one registered result per vector and a count of vectors
// whose result is 1.
//
// Parameters:
//   N    - gate input width (2..8)
//   HOLD - clock cycles each vector is held before advancing (1..255)
//
// Ports:
//   clk      - single clock, rising edge
//   reset    - asynchronous active-high reset
//   start    - sweep request, accepted only while idle
//   mode     - gate select: 000 AND, 001 OR, 010 XOR, 011 NAND,
//              100 NOR, 101 XNOR, 110 majority, 111 constant 0
//   vec      - current stimulus vector
//   d        - registered gate result (one cycle behind vec)
//   valid    - d is the final result for a completed vector
//   busy     - high while the sweep is in progress
//   done     - one-cycle end-of-sweep pulse, coincident with the last valid
//   ones_cnt - number of completed vectors whose result was 1
//
// Build option:
//   GATES_SWEEP_ONES_CNT_EN - when defined, ones_cnt counts; otherwise the
//                             port is tied to 0 and no counter is built.
module gates_sweep #(
  parameter int unsigned N    = 3,
  parameter int unsigned HOLD = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   mode,
  output logic [N-1:0] vec,
  output logic         d,
  output logic         valid,
  output logic         busy,
  output logic         done,
  output logic [N:0]   ones_cnt
);

  typedef enum logic {
    IDLE,
    SWEEP
  } state_t;

  typedef enum logic [2:0] {
    G_AND  = 3'b000,
    G_OR   = 3'b001,
    G_XOR  = 3'b010,
    G_NAND = 3'b011,
    G_NOR  = 3'b100,
    G_XNOR = 3'b101,
    G_MAJ  = 3'b110,
    G_ZERO = 3'b111
  } gate_t;

  localparam logic [7:0] HOLD_LAST = 8'(HOLD - 1);
  localparam logic [3:0] MAJ_THR   = 4'(N / 2);

  state_t     state;
  gate_t      mode_l;
  logic [7:0] hold_cnt;
  logic [3:0] pop;
  logic       gate_out;
  logic       vec_end;
  logic       last_vec;

  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N; i++) begin
      pop = pop + {3'b000, vec[i]};
    end
  end

  always_comb begin
    gate_out = 1'b0;
    case (mode_l)
      G_AND:   gate_out = &vec;
      G_OR:    gate_out = |vec;
      G_XOR:   gate_out = ^vec;
      G_NAND:  gate_out = ~&vec;
      G_NOR:   gate_out = ~|vec;
      G_XNOR:  gate_out = ~^vec;
      G_MAJ:   gate_out = (pop > MAJ_THR);
      G_ZERO:  gate_out = 1'b0;
      default: gate_out = 1'b0;
    endcase
  end

  // The edge that ends the hold of a vector is the edge that reports it.
  assign vec_end  = (hold_cnt == HOLD_LAST);
  assign last_vec = vec_end && (vec == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_l   <= G_AND;
      vec      <= '0;
      hold_cnt <= '0;
      d        <= 1'b0;
      valid    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          d     <= 1'b0;
          valid <= 1'b0;
          done  <= 1'b0;
          if (start) begin
            state    <= SWEEP;
            mode_l   <= gate_t'(mode);
            vec      <= '0;
            hold_cnt <= '0;
            busy     <= 1'b1;
          end
        end
        SWEEP: begin
          d     <= gate_out;
          valid <= vec_end;
          done  <= last_vec;
          if (vec_end) begin
            hold_cnt <= '0;
            vec      <= vec + 1'b1;   // wraps to 0 on the final edge
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (last_vec) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef GATES_SWEEP_ONES_CNT_EN
  // Counts at the same edge valid/d are registered, so the final total is
  // already visible in the done cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ones_cnt <= '0;
    end else if (state == IDLE) begin
      if (start) begin
        ones_cnt <= '0;
      end
    end else if (vec_end && gate_out) begin
      ones_cnt <= ones_cnt + 1'b1;
    end
  end
`else
  assign ones_cnt = '0;
`endif

endmodule

// File: doc/gates_sweep.md
GATES_SWEEP -- requirements
Module: gates_sweep

Interface
REQ-001 SHALL have parameter N, default 3, giving the gate input width; legal range 2..8.
REQ-002 SHALL have parameter HOLD, default 1, giving the clock cycles each vector is held; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: sweep request, sampled at a clk edge.
REQ-006 SHALL have port mode, input, 3 bits: gate select.
- 000 AND, 001 OR, 010 XOR, 011 NAND.
- 100 NOR, 101 XNOR, 110 majority (popcount > N/2, integer division), 111 constant 0.
REQ-007 SHALL have port vec, output, N bits: current stimulus vector.
REQ-008 SHALL have port d, output, 1 bit: registered gate result.
REQ-009 SHALL have port valid, output, 1 bit: d is the final result for a completed vector.
REQ-010 SHALL have port busy, output, 1 bit: high while the sweep is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle end-of-sweep pulse.
REQ-012 SHALL have port ones_cnt, output, N+1 bits: number of vectors for which d=1.

Function
REQ-013 SHALL implement a two-state FSM: IDLE and SWEEP.
REQ-014 SHALL, in IDLE, move to SWEEP on an edge where start=1, latching mode and clearing vec, the hold counter and ones_cnt at that edge (E0).
REQ-015 SHALL ignore start while in SWEEP, and SHALL ignore mode changes after E0 until the next accepted start.
REQ-016 SHALL hold each vec value for exactly HOLD cycles, then increment vec by 1, modulo 2^N.
REQ-017 SHALL update d every edge to gate(latched mode, vec as sampled at that edge): one cycle of latency.
REQ-018 SHALL assert valid for one cycle at edge E0+(k+1)*HOLD for vector k, k = 0..2^N-1; d in that cycle is gate(k).
REQ-019 SHALL increment ones_cnt when valid=1 and d=1; ones_cnt holds its value in IDLE until the next accepted start.
REQ-020 SHALL assert done together with the last valid, at edge E0+2^N*HOLD, and SHALL return to IDLE at that same edge.
REQ-021 SHALL let vec wrap from all-ones to 0 at the final edge, with no extra vector applied.
REQ-022 SHALL keep busy=1 exactly while in SWEEP, covering 2^N*HOLD cycles.
REQ-023 SHALL, for start=1 on the done edge, ignore that start; start is accepted from the following edge.
REQ-024 SHALL hold d, valid and done at 0 in IDLE, except for the done/valid pulse cycle.

Reset
REQ-025 SHALL, on reset=1, immediately and independent of clk, force IDLE and vec=0, d=0, valid=0, busy=0, done=0, ones_cnt=0 and latched mode=000.
REQ-026 SHALL abort an in-progress sweep on reset with no done pulse; a new sweep requires start after reset is released.

Configuration
REQ-027 SHALL, with macro GATES_SWEEP_ONES_CNT_EN defined, implement the ones_cnt counter per REQ-019.
REQ-028 SHALL, without GATES_SWEEP_ONES_CNT_EN, keep the ones_cnt port present, tied to constant 0, with no counter logic; all other behaviour is unchanged.

Verification (N=3, HOLD=1 unless stated; macro defined unless stated)
REQ-029 SHALL cover: mode=000, start pulse -> vec 0..7 on consecutive cycles, valid x8, d=1 only for vec 7, done at E0+8, ones_cnt=1, busy low after E0+8.
REQ-030 SHALL cover: modes 010 / 110 / 100 -> ones_cnt = 4 / 4 / 1 respectively; mode 111 -> ones_cnt = 0.
REQ-031 SHALL cover: HOLD=3, mode=001 -> each vec held 3 cycles, valid at E0+3, +6, ... +24, done at E0+24, ones_cnt=7.
REQ-032 SHALL cover: start re-pulsed and mode switched 000->001 mid-sweep -> sweep unaffected, ones_cnt=1, single done.
REQ-033 SHALL cover: reset asserted between edges at vec=5 -> all outputs 0 before the next edge, no done; a fresh start then sweeps from vec=0.
REQ-034 SHALL cover: N=4, mode=101, macro undefined -> 16 valid pulses, done at E0+16, ones_cnt constant 0 throughout.
